// File: rtl/pipe_ctrl.sv
// Five-stage pipeline controller: resolves stage stall requests and MEM-stage
// exception redirects into per-register stall/flush vectors, with a stall-cycle counter.
module pipe_ctrl #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_stallreq,
    input  logic             id_stallreq,
    input  logic             ex_stallreq,
    input  logic             mem_stallreq,
    input  logic             exc_flag,
    input  logic [PC_W-1:0]  exc_newpc,
    input  logic             if_busy,
    output logic [4:0]       stall,
    output logic [4:0]       flush,
    output logic             redir_en,
    output logic [PC_W-1:0]  redir_pc,
    output logic             wait_if,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic {IDLE, WAIT_IF} state_t;

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc_q;
    logic [3:0]      req;
    logic [4:0]      stall_c, flush_c;
    logic            redir_c, latch_c;

    assign req = {mem_stallreq, ex_stallreq, id_stallreq, if_stallreq};

    always_comb begin
        state_nxt = state;
        stall_c   = 5'b00000;
        flush_c   = 5'b00000;
        redir_c   = 1'b0;
        latch_c   = 1'b0;
        case (state)
            IDLE: begin
                if (exc_flag) begin
                    flush_c = 5'b11110;
                    if (if_busy) begin
                        // Fetch in flight: hold PC until the bus drains, then redirect.
                        stall_c   = 5'b00001;
                        latch_c   = 1'b1;
                        state_nxt = WAIT_IF;
                    end else begin
                        redir_c = 1'b1;
                    end
                end else begin
                    casez (req)
                        4'b1???: begin stall_c = 5'b01111; flush_c = 5'b10000; end
                        4'b01??: begin stall_c = 5'b00111; flush_c = 5'b01000; end
                        4'b001?: begin stall_c = 5'b00011; flush_c = 5'b00100; end
                        4'b0001: begin stall_c = 5'b00001; flush_c = 5'b00010; end
                        default: ;
                    endcase
                end
            end
            WAIT_IF: begin
                flush_c = 5'b11110;
                latch_c = exc_flag;
                if (if_busy) begin
                    stall_c = 5'b00001;
                end else begin
                    redir_c   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pc_q      <= '0;
            stall_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (latch_c)
                pc_q <= exc_newpc;
            if (stall_c[0] && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // Outputs are forced low for as long as reset is held.
    assign stall    = rst ? 5'b00000 : stall_c;
    assign flush    = rst ? 5'b00000 : flush_c;
    assign redir_en = rst ? 1'b0 : redir_c;
    assign redir_pc = rst ? '0 : ((state == WAIT_IF) ? pc_q : exc_newpc);
    assign wait_if  = !rst && (state == WAIT_IF);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed literal checks plus randomized traffic compared
// every cycle against a behavioural model (two DUTs: 32-bit and 4-bit counters).
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_sr = 0, id_sr = 0, ex_sr = 0, mem_sr = 0;
    logic        exc_flag = 0, if_busy = 0;
    logic [31:0] exc_newpc = '0;

    logic [4:0]  stall, flush, stall4, flush4;
    logic        redir_en, wait_if, redir_en4, wait_if4;
    logic [31:0] redir_pc, redir_pc4, stall_cnt;
    logic [3:0]  stall_cnt4;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.PC_W(32), .CNT_W(32)) u_dut (
        .clk(clk), .rst(rst), .if_stallreq(if_sr), .id_stallreq(id_sr),
        .ex_stallreq(ex_sr), .mem_stallreq(mem_sr), .exc_flag(exc_flag),
        .exc_newpc(exc_newpc), .if_busy(if_busy), .stall(stall), .flush(flush),
        .redir_en(redir_en), .redir_pc(redir_pc), .wait_if(wait_if),
        .stall_cnt(stall_cnt));

    pipe_ctrl #(.PC_W(32), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .if_stallreq(if_sr), .id_stallreq(id_sr),
        .ex_stallreq(ex_sr), .mem_stallreq(mem_sr), .exc_flag(exc_flag),
        .exc_newpc(exc_newpc), .if_busy(if_busy), .stall(stall4), .flush(flush4),
        .redir_en(redir_en4), .redir_pc(redir_pc4), .wait_if(wait_if4),
        .stall_cnt(stall_cnt4));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    bit          m_wait;
    logic [31:0] m_pc;
    longint      m_cnt;

    function automatic void model_out(output logic [4:0] s, output logic [4:0] f,
                                      output logic r, output logic [31:0] p);
        logic [3:0] rq;
        int d;
        s = 0; f = 0; r = 0; p = 0;
        if (rst) return;
        if (exc_flag || m_wait) begin
            f = 5'b11110;
            if (if_busy) s = 5'b00001;
            else r = 1'b1;
            p = m_wait ? m_pc : exc_newpc;
        end else begin
            rq = {mem_sr, ex_sr, id_sr, if_sr};
            d = -1;
            for (int i = 0; i < 4; i++) if (rq[i]) d = i;
            if (d >= 0) begin
                s = 5'((32'd1 << (d + 1)) - 1);
                f = 5'(32'd1 << (d + 1));
            end
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        logic [4:0] s, f;
        logic r;
        logic [31:0] p;
        if (rst) begin
            m_wait <= 1'b0;
            m_pc   <= '0;
            m_cnt  <= 0;
        end else begin
            model_out(s, f, r, p);
            if (s[0]) m_cnt <= m_cnt + 1;
            if (m_wait) begin
                if (exc_flag) m_pc <= exc_newpc;
                m_wait <= if_busy;
            end else if (exc_flag && if_busy) begin
                m_pc   <= exc_newpc;
                m_wait <= 1'b1;
            end
        end
    end

    // Single compare process, sampled mid-cycle.
    always @(negedge clk) begin
        logic [4:0] s, f;
        logic r;
        logic [31:0] p;
        model_out(s, f, r, p);
        chk("stall", stall, s);
        chk("flush", flush, f);
        chk("redir_en", redir_en, r);
        if (r) chk("redir_pc", redir_pc, p);
        chk("wait_if", wait_if, !rst && m_wait);
        chk("stall_cnt", stall_cnt, (m_cnt > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_cnt);
        chk("stall_cnt4", stall_cnt4, (m_cnt > 15) ? 15 : m_cnt);
        chk("stall4", stall4, s);
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic [3:0] rq, input logic e, input logic [31:0] npc, input logic b);
        @(posedge clk); #1;
        {mem_sr, ex_sr, id_sr, if_sr} = rq;
        exc_flag = e; exc_newpc = npc; if_busy = b;
        #1;
    endtask

    initial begin
        #3;
        chk("rst_stall", stall, 0);
        chk("rst_flush", flush, 0);
        chk("rst_wait", wait_if, 0);
        chk("rst_cnt", stall_cnt, 0);
        @(posedge clk); #1 rst = 1'b0;

        // 1: single requests
        step(4'b0001, 0, 0, 0); chk("t1_if_s", stall, 5'b00001); chk("t1_if_f", flush, 5'b00010);
        step(4'b0010, 0, 0, 0); chk("t1_id_s", stall, 5'b00011); chk("t1_id_f", flush, 5'b00100);
        step(4'b0100, 0, 0, 0); chk("t1_ex_s", stall, 5'b00111); chk("t1_ex_f", flush, 5'b01000);
        step(4'b1000, 0, 0, 0); chk("t1_mem_s", stall, 5'b01111); chk("t1_mem_f", flush, 5'b10000);
        step(4'b1010, 0, 0, 0); chk("t1_mix_s", stall, 5'b01111); chk("t1_mix_f", flush, 5'b10000);
        step(4'b0000, 0, 0, 0); chk("t1_cnt", stall_cnt, 5);

        // 2: id+ex held 3 cycles
        repeat (3) begin
            step(4'b0110, 0, 0, 0);
            chk("t2_s", stall, 5'b00111); chk("t2_f", flush, 5'b01000);
        end
        step(4'b0000, 0, 0, 0); chk("t2_cnt", stall_cnt, 8);

        // 3: exception, fetch idle; stallreqs ignored
        step(4'b1111, 1, 32'hBFC00380, 0);
        chk("t3_f", flush, 5'b11110); chk("t3_s", stall, 0);
        chk("t3_r", redir_en, 1); chk("t3_pc", redir_pc, 32'hBFC00380);
        step(4'b0000, 0, 0, 0); chk("t3_wait", wait_if, 0);

        // 4: exception with fetch outstanding
        step(4'b0000, 1, 32'h80000180, 1);
        chk("t4_s0", stall, 5'b00001); chk("t4_r0", redir_en, 0);
        repeat (3) begin
            step(4'b0100, 0, 0, 1);
            chk("t4_wait", wait_if, 1); chk("t4_s", stall, 5'b00001); chk("t4_f", flush, 5'b11110);
        end
        step(4'b0000, 0, 0, 0);
        chk("t4_r", redir_en, 1); chk("t4_pc", redir_pc, 32'h80000180); chk("t4_s1", stall, 0);
        step(4'b0000, 0, 0, 0); chk("t4_idle", wait_if, 0); chk("t4_cnt", stall_cnt, 12);

        // 5: newer exception during WAIT_IF wins
        step(4'b0000, 1, 32'h80000400, 1);
        step(4'b0000, 1, 32'h80000200, 1);
        step(4'b0000, 0, 32'h12345678, 0);
        chk("t5_r", redir_en, 1); chk("t5_pc", redir_pc, 32'h80000200);

        // 6: reset in WAIT_IF
        step(4'b0000, 1, 32'h80000180, 1);
        step(4'b0000, 0, 0, 1);
        chk("t6_wait", wait_if, 1);
        rst = 1'b1; #1;
        chk("t6_rs", stall, 0); chk("t6_rf", flush, 0); chk("t6_rw", wait_if, 0);
        chk("t6_rc", stall_cnt, 0); chk("t6_rr", redir_en, 0);
        @(posedge clk); #1 rst = 1'b0;
        step(4'b0000, 0, 0, 0);
        chk("t6_nored", redir_en, 0); chk("t6_idle", wait_if, 0);

        // counter saturation in the 4-bit instance
        repeat (20) step(4'b0001, 0, 0, 0);
        step(4'b0000, 0, 0, 0);
        chk("sat4", stall_cnt4, 15); chk("cnt20", stall_cnt, 20);

        // randomized traffic
        repeat (3000) begin
            logic e, b;
            b = ($urandom_range(0, 3) != 0) ? if_busy : $urandom_range(0, 1);
            e = ($urandom_range(0, 7) == 0);
            // Skip the exception-on-release corner in WAIT_IF.
            if (m_wait && !b) e = 1'b0;
            step(4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)), e, $urandom, b);
        end

        @(posedge clk); #1;
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
